// File: rtl/core_seq.sv
// core_seq: program-load and run sequencer for the mips32 core.
// Streams words into imem, then owns core reset, clock enable and watchdog.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start_load/run_start one-cycle requests (LOAD wins when both are high)
//   abort                return to IDLE from any state
//   ld_valid/ld_data     load stream, ld_last marks the final word
//   ld_ready             high in LOAD (one word per cycle)
//   imem_we/addr/wdata   combinational write port, valid on a handshake
//   core_rst             active-high core reset (high in IDLE/LOAD/CRST)
//   core_clk_en          core clock enable (high only in RUN)
//   hlt_in               halt flag from the core
//   busy/done/timeout    status; timeout = DONE reached via watchdog
//   inst_count           words in the last completed load
//   cycle_count          RUN cycles in the current or last run
//   state                IDLE=0 LOAD=1 CRST=2 RUN=3 DONE=4
module core_seq #(
  parameter int ADDR_W     = 10,
  parameter int MAX_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic              run_start,
  input  logic              abort,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              core_clk_en,
  input  logic              hlt_in,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ADDR_W:0]   inst_count,
  output logic [31:0]       cycle_count,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CRST = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [31:0]     LIMIT = 32'(MAX_CYCLES - 1);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     icnt_q, icnt_d;
  logic [31:0]         cyc_q, cyc_d;
  logic                tmo_q, tmo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      icnt_q   <= '0;
      cyc_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      icnt_q   <= icnt_d;
      cyc_q    <= cyc_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    icnt_d      = icnt_q;
    cyc_d       = cyc_q;
    tmo_d       = tmo_q;
    ld_ready    = 1'b0;
    imem_we     = 1'b0;
    core_rst    = 1'b1;
    core_clk_en = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_load) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
        end else if (run_start) begin
          state_d = S_CRST;
        end
      end

      S_LOAD: begin
        busy     = 1'b1;
        ld_ready = 1'b1;
        if (ld_valid) begin
          imem_we  = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          // Stop at the last slot so the pointer never wraps onto word 0.
          if (ld_last || (wr_ptr_q == '1)) begin
            icnt_d  = {1'b0, wr_ptr_q} + ONE;
            state_d = S_IDLE;
          end
        end
      end

      S_CRST: begin
        busy    = 1'b1;
        cyc_d   = '0;
        tmo_d   = 1'b0;
        state_d = S_RUN;
      end

      S_RUN: begin
        busy        = 1'b1;
        core_rst    = 1'b0;
        core_clk_en = 1'b1;
        // Halt takes priority over the watchdog on the same cycle.
        if (hlt_in) begin
          cyc_d   = cyc_q + 32'd1;
          state_d = S_DONE;
        end else if (cyc_q == LIMIT) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end

      S_DONE: begin
        core_rst = 1'b0;
        done     = 1'b1;
        if (start_load) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
        end else if (run_start) begin
          state_d = S_CRST;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An aborted load never publishes its word count.
    if (abort) begin
      state_d = S_IDLE;
      icnt_d  = icnt_q;
    end
  end

  assign imem_addr   = wr_ptr_q;
  assign imem_wdata  = ld_data;
  assign timeout     = tmo_q;
  assign inst_count  = icnt_q;
  assign cycle_count = cyc_q;
  assign state       = state_q;

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: randomized self-checking bench for core_seq.
// Small instance (4-word imem, 8-cycle watchdog) against a transaction model.
module tb_core_seq;

  localparam int AW    = 2;
  localparam int MC    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_load, run_start, abort;
  logic          ld_valid, ld_last, ld_ready;
  logic [31:0]   ld_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst, core_clk_en, hlt_in;
  logic          busy, done, timeout;
  logic [AW:0]   inst_count;
  logic [31:0]   cycle_count;
  logic [2:0]    state;

  core_seq #(.ADDR_W(AW), .MAX_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_load(start_load), .run_start(run_start), .abort(abort),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .core_clk_en(core_clk_en), .hlt_in(hlt_in),
    .busy(busy), .done(done), .timeout(timeout),
    .inst_count(inst_count), .cycle_count(cycle_count), .state(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory seen by the bench: the DUT's writes, and what the model expects.
  logic [31:0] shadow  [DEPTH];
  logic [31:0] mem_ref [DEPTH];
  int          wr_a[$];
  logic [31:0] wr_d[$];
  int          exp_icnt = 0;

  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      wr_a.push_back(int'(imem_addr));
      wr_d.push_back(imem_wdata);
      shadow[imem_addr] = imem_wdata;
    end
  end

  task automatic reset_checks(input string p);
    check({p, "_state"}, state, 0);
    check({p, "_core_rst"}, core_rst, 1);
    check({p, "_clk_en"}, core_clk_en, 0);
    check({p, "_ld_ready"}, ld_ready, 0);
    check({p, "_imem_we"}, imem_we, 0);
    check({p, "_done"}, done, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_timeout"}, timeout, 0);
    check({p, "_inst_count"}, inst_count, 0);
    check({p, "_cycle_count"}, cycle_count, 0);
  endtask

  // pat: per-cycle valid pattern; abort_at: pattern index of abort, or -1.
  task automatic do_load(input logic [31:0] words[$], input bit pat[$],
                         input bit use_last, input int abort_at);
    int          wi;
    int          acc;
    bit          loading;
    int          ea[$];
    logic [31:0] ed[$];
    wi      = 0;
    acc     = 0;
    loading = 1'b1;
    @(negedge clk);
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    wr_a.delete();
    wr_d.delete();
    #1;
    check("ld_ready_first", ld_ready, 1);
    check("load_state", state, 1);
    for (int c = 0; c < pat.size(); c++) begin
      ld_valid = 1'b0;
      ld_data  = $urandom;
      ld_last  = 1'($urandom);
      if (c == abort_at) begin
        abort   = 1'b1;
        loading = 1'b0;
      end else if (pat[c] && wi < words.size()) begin
        ld_valid = 1'b1;
        ld_data  = words[wi];
        ld_last  = use_last && (wi == words.size() - 1);
        if (loading) begin
          ea.push_back(acc);
          ed.push_back(words[wi]);
          mem_ref[acc] = words[wi];
          acc++;
          if (ld_last || acc == DEPTH) begin
            loading  = 1'b0;
            exp_icnt = acc;
          end
        end
        wi++;
      end
      @(negedge clk);
      abort = 1'b0;
      if (c == abort_at) break;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1;
    check("load_end_state", state, loading ? 1 : 0);
    check("load_ready_after", ld_ready, loading ? 1 : 0);
    check("inst_count", inst_count, exp_icnt);
    check("wr_count", wr_a.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wr_a.size(); i++) begin
      check("wr_addr", wr_a[i], ea[i]);
      check("wr_data", wr_d[i], ed[i]);
    end
    for (int i = 0; i < DEPTH; i++) check("mem", shadow[i], mem_ref[i]);
  endtask

  // h: RUN cycle (1-based) on which hlt_in is raised; 0 = never.
  task automatic do_run(input int h);
    int runs;
    int guard;
    bit to;
    runs  = 0;
    guard = 0;
    to    = (h == 0) || (h > MC);
    @(negedge clk);
    run_start = 1'b1;
    @(negedge clk);
    run_start = 1'b0;
    wr_a.delete();
    #1;
    check("crst_state", state, 2);
    check("crst_core_rst", core_rst, 1);
    check("crst_clk_en", core_clk_en, 0);
    do begin
      @(negedge clk);
      #1;
      hlt_in = 1'b0;
      if (core_clk_en) begin
        runs++;
        hlt_in = (runs == h);
        check("run_core_rst", core_rst, 0);
      end
      guard++;
    end while (core_clk_en && guard < 4 * MC);
    hlt_in = 1'b0;
    check("run_cycles", runs, to ? MC : h);
    check("done_state", state, 4);
    check("done_flag", done, 1);
    check("done_busy", busy, 0);
    check("done_core_rst", core_rst, 0);
    check("cycle_count", cycle_count, to ? MC - 1 : h);
    check("timeout", timeout, to);
    check("run_no_writes", wr_a.size(), 0);
    repeat (2) @(negedge clk);
    #1;
    check("done_hold_cnt", cycle_count, to ? MC - 1 : h);
    check("done_hold_en", core_clk_en, 0);
  endtask

  initial begin
    logic [31:0] w[$];
    bit          p[$];
    int          n;
    bit          ul;
    rst_n      = 1'b0;
    start_load = 1'b0;
    run_start  = 1'b0;
    abort      = 1'b0;
    ld_valid   = 1'b0;
    ld_last    = 1'b0;
    ld_data    = '0;
    hlt_in     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      shadow[i]  = '0;
      mem_ref[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;

    w = '{32'h0000_0001, 32'h0000_0002, 32'hFC00_0000};
    p = '{1, 1, 1};
    do_load(w, p, 1'b1, -1);

    w = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};
    p = '{1, 0, 1, 1};
    do_load(w, p, 1'b1, -1);

    w = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
    p = '{1, 1, 1, 1, 1, 1};
    do_load(w, p, 1'b0, -1);

    do_run(5);
    do_run(0);
    do_run(MC);

    w = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002};
    p = '{1, 1, 0, 1};
    do_load(w, p, 1'b1, 2);

    @(negedge clk);
    start_load = 1'b1;
    run_start  = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    run_start  = 1'b0;
    #1;
    check("both_req_state", state, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_state", state, 0);
    check("abort_icnt", inst_count, exp_icnt);

    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        n  = $urandom_range(1, 6);
        ul = (n < DEPTH) ? 1'b1 : 1'($urandom);
        w.delete();
        p.delete();
        for (int k = 0; k < n; k++) w.push_back($urandom);
        for (int k = 0; k < n; ) begin
          if ($urandom_range(0, 3) == 0) p.push_back(1'b0);
          else begin
            p.push_back(1'b1);
            k++;
          end
        end
        do_load(w, p, ul, -1);
      end else begin
        do_run($urandom_range(0, MC + 2));
      end
    end

    @(negedge clk);
    run_start = 1'b1;
    @(negedge clk);
    run_start = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_icnt = 0;
    reset_checks("midrun_rst");
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
